// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction/data memory fetch arbiter.
package imem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        IF = 1'b0,
        DM = 1'b1
    } port_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned CNT_W          = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way grant decision: a lone requester always wins; on a tie the port
// that did not win last time is chosen.
module rr_arbiter2
    import imem_arb_pkg::*;
(
    input  logic  req_if,
    input  logic  req_dm,
    input  port_t last_grant,
    output port_t grant
);

    always_comb begin
        grant = DM;
        if (req_if && req_dm) begin
            grant = (last_grant == IF) ? DM : IF;
        end else if (req_if) begin
            grant = IF;
        end
    end

endmodule

// File: rtl/imem_fetch_arb.sv
// Shares a byte-wide memory between fetch and load ports, assembling 32-bit
// big-endian words. Define IMEM_ARB_RR_EN for round-robin tie breaking.
module imem_fetch_arb
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic [31:0]       dm_addr,
    output logic              dm_ack,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    state_t             state;
    port_t              granted;
    port_t              grant;
    port_t              last_grant;
    logic [ADDR_W-1:0]  base;
    logic [CNT_W-1:0]   cnt;
    logic [23:0]        asm_q;
    logic               addr_hi_unused;

    assign addr_hi_unused = ^{if_addr[31:ADDR_W], dm_addr[31:ADDR_W]};

    rr_arbiter2 u_arb (
        .req_if     (if_req),
        .req_dm     (dm_req),
        .last_grant (last_grant),
        .grant      (grant)
    );

`ifndef IMEM_ARB_RR_EN
    // Pinning the history to IF makes the arbiter hand every tie to DM.
    assign last_grant = IF;
`endif

    // Bytes accumulate in asm_q so rdata keeps the previous word until the
    // final byte lands; ack is registered on the DONE->IDLE edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            granted <= DM;
            base    <= '0;
            cnt     <= '0;
            asm_q   <= '0;
            rdata   <= '0;
            if_ack  <= 1'b0;
            dm_ack  <= 1'b0;
`ifdef IMEM_ARB_RR_EN
            last_grant <= DM;
`endif
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (if_req || dm_req) begin
                        granted <= grant;
                        base    <= (grant == DM) ? dm_addr[ADDR_W-1:0]
                                                 : if_addr[ADDR_W-1:0];
                        cnt     <= '0;
                        state   <= READ;
`ifdef IMEM_ARB_RR_EN
                        last_grant <= grant;
`endif
                    end
                end
                READ: begin
                    if (cnt == CNT_W'(BYTES_PER_WORD - 1)) begin
                        rdata <= {asm_q, mem_rdata};
                        state <= DONE;
                    end else begin
                        asm_q <= {asm_q[15:0], mem_rdata};
                    end
                    cnt <= cnt + 1'b1;
                end
                DONE: begin
                    if_ack <= (granted == IF);
                    dm_ack <= (granted == DM);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_en   = (state == READ);
    assign mem_addr = (state == READ) ? base + ADDR_W'(cnt) : '0;
    assign busy     = (state != IDLE);

endmodule
